// File: rtl/decoder_3to8_reg.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_3to8_reg
//  Description : Registered 3-to-8 line decoder. The three select bits
//                {in1, in2, in3} form a 3-bit index (in1 = MSB). The
//                decoded one-hot code is registered and appears on `out` one
//                clock after the inputs are sampled. `out_vld` marks a valid
//                decode.
//
//  Ports       : clk     - system clock, rising-edge active
//                rst     - synchronous reset, active-high (beats en/selects)
//                en      - decode enable; when low the output is cleared
//                in1     - select bit 2 (MSB)
//                in2     - select bit 1
//                in3     - select bit 0 (LSB)
//                out     - registered one-hot decode (8 bits)
//                out_vld - high when out holds a valid decode
//
//  Options     : DECODER_ACTIVE_LOW_EN
//                  Defined     : out is active-low (selected bit 0, all
//                                others 1). Reset and en = 0 give 8'hFF.
//                  Not defined : out is active-high one-hot, idle 8'h00.
//                out_vld polarity is the same in both builds.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder_3to8_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in1,
    input  logic       in2,
    input  logic       in3,
    output logic [7:0] out,
    output logic       out_vld
);

    // Value driven on out whenever there is no valid decode (reset or en = 0)
`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic [7:0] c_IDLE_CODE = 8'hFF;
`else
    localparam logic [7:0] c_IDLE_CODE = 8'h00;
`endif

    logic [2:0] w_idx;
    logic [7:0] w_onehot;
    logic [7:0] w_code;
    logic [7:0] r_out;
    logic       r_out_vld;

    assign w_idx    = {in1, in2, in3};
    // A shift of a single set bit yields exactly one hot bit for every
    // legal index; an X/Z select propagates X for that cycle only.
    assign w_onehot = 8'b0000_0001 << w_idx;

`ifdef DECODER_ACTIVE_LOW_EN
    assign w_code   = ~w_onehot;
`else
    assign w_code   = w_onehot;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out     <= c_IDLE_CODE;
            r_out_vld <= 1'b0;
        end else if (en) begin
            r_out     <= w_code;
            r_out_vld <= 1'b1;
        end else begin
            // Disabled: clear rather than hold, so out never shows a stale code
            r_out     <= c_IDLE_CODE;
            r_out_vld <= 1'b0;
        end
    end

    assign out     = r_out;
    assign out_vld = r_out_vld;

endmodule
`default_nettype wire

// File: tb/tb_decoder_3to8_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoder_3to8_reg
//  Description : Self-checking bench for decoder_3to8_reg. A stimulus process
//                pushes the expected {out_vld, out} for every edge into a
//                queue; a monitor pops and compares one entry per edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_3to8_reg;

    logic       clk;
    logic       rst;
    logic       en;
    logic       in1;
    logic       in2;
    logic       in3;
    logic [7:0] out;
    logic       out_vld;

    int errors = 0;
    int checks = 0;

    logic [8:0] exp_q[$];   // {vld, out}

    decoder_3to8_reg dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .in1     (in1),
        .in2     (in2),
        .in3     (in3),
        .out     (out),
        .out_vld (out_vld)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: out has bit idx set (2**idx) when decoding, zero otherwise;
    // the active-low build is the bitwise complement of that.
    function automatic logic [8:0] model(input bit r, input bit e, input int idx);
        logic [7:0] o;
        bit         v;
        v = !r && e;
        o = v ? 8'(2 ** idx) : 8'h00;
`ifdef DECODER_ACTIVE_LOW_EN
        o = ~o;
`endif
        return {v, o};
    endfunction

    function automatic logic [7:0] idle_code();
        logic [8:0] m;
        m = model(1'b1, 1'b0, 0);
        return m[7:0];
    endfunction

    // One edge of stimulus: drive on the falling edge, record what the next
    // rising edge must produce.
    task automatic step(input bit r, input bit e, input int idx);
        logic [2:0] s;
        @(negedge clk);
        s   = 3'(idx);
        rst = r;
        en  = e;
        {in1, in2, in3} = s;
        exp_q.push_back(model(r, e, idx));
    endtask

    // Monitor: one response per rising edge, sampled 1 ns after it
    initial begin
        logic [8:0] e;
        logic [7:0] act_hot;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (out !== e[7:0]) begin
                    errors++;
                    $display("FAIL out: got %h expected %h at %0t", out, e[7:0], $time);
                end
                checks++;
                if (out_vld !== e[8]) begin
                    errors++;
                    $display("FAIL out_vld: got %b expected %b at %0t", out_vld, e[8], $time);
                end
`ifdef DECODER_ACTIVE_LOW_EN
                act_hot = ~out;
`else
                act_hot = out;
`endif
                checks++;
                if (out_vld === 1'b1 ? ($countones(act_hot) != 1) : (out !== idle_code())) begin
                    errors++;
                    $display("FAIL invariant: out=%h out_vld=%b at %0t", out, out_vld, $time);
                end
            end
        end
    end

    initial begin
        logic [8:0] prev;
        rst = 1'b0; en = 1'b0; in1 = 1'b0; in2 = 1'b0; in3 = 1'b0;

        // Reset held two cycles with a live select, then release
        step(1, 1, 5);
        step(1, 1, 5);
        step(0, 1, 5);

        // Exhaustive walk of all indices
        for (int i = 0; i < 8; i++) step(0, 1, i);

        // Enable gating: cleared on en = 0, restored on re-enable
        step(0, 1, 2);
        step(0, 0, 2);
        step(0, 1, 2);

        // Mid-cycle glitch 011 -> 110 -> 011 between edges
        step(0, 1, 3);
        step(0, 1, 3);
        prev = model(0, 1, 3);
        #1 {in1, in2, in3} = 3'b110;
        #1;
        checks++;
        if (out !== prev[7:0]) begin
            errors++;
            $display("FAIL glitch_hold: got %h expected %h at %0t", out, prev[7:0], $time);
        end
        #1 {in1, in2, in3} = 3'b011;

        // Reset priority and single-cycle reset pulse mid-operation
        step(1, 1, 7);
        step(0, 1, 7);
        step(0, 1, 4);
        step(1, 1, 4);
        step(0, 1, 6);

        // 100 random cycles with en = 1
        for (int i = 0; i < 100; i++) step(0, 1, int'($urandom_range(0, 7)));

        // Random mix of rst/en/selects
        for (int i = 0; i < 40; i++)
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 7)));

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
